// File: rtl/lcd_axil_pkg.sv
// Shared constants for the AXI4-Lite LCD controller.
// Register indices, response codes, sequencer states.
package lcd_axil_pkg;

  localparam int CMD_IDX    = 0;
  localparam int STATUS_IDX = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } seq_state_e;

endpackage

// File: rtl/lcd_bus_seq.sv
// LCD bus sequencer: SETUP -> PULSE (E high) -> HOLD.
// Ports: clk_i/rst_i, start_i with data_i/rs_i, LCD bus
// outputs, busy_o (not IDLE), done_o (last HOLD cycle).
module lcd_bus_seq
  import lcd_axil_pkg::*;
#(
  parameter int E_PULSE_CYCLES = 50,
  parameter int HOLD_CYCLES    = 2000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       rs_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int MAXC = (E_PULSE_CYCLES > HOLD_CYCLES) ?
                        E_PULSE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          e_q;
  logic          busy_q;

  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_e_o    = e_q;
  assign busy_o     = busy_q;
  // Final HOLD cycle; the completed-command count bumps here.
  assign done_o     = (state_q == ST_HOLD) && (cnt_q == '0);

  // One down-counter times both PULSE and HOLD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_SETUP;
            data_q  <= data_i;
            rs_q    <= rs_i;
            busy_q  <= 1'b1;
          end
        end
        ST_SETUP: begin
          state_q <= ST_PULSE;
          e_q     <= 1'b1;
          cnt_q   <= CW'(E_PULSE_CYCLES - 1);
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= ST_HOLD;
            e_q     <= 1'b0;
            cnt_q   <= CW'(HOLD_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_axil_ctrl.sv
// AXI4-Lite slave: CMD, STATUS and scratch registers,
// driving an HD44780-style LCD bus via lcd_bus_seq.
// Ports: s00_axi_* AXI4-Lite slave, lcd_data/rs/e, lcd_busy.
module lcd_axil_ctrl
  import lcd_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 8,
  parameter int E_PULSE_CYCLES     = 50,
  parameter int HOLD_CYCLES        = 2000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [7:0]                      lcd_data,
  output logic                            lcd_rs,
  output logic                            lcd_e,
  output logic                            lcd_busy
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam int NB = DW / 8;

  // Assert asynchronously, release after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) rst_sync_q <= 2'b11;
    else                rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  logic          awrdy_q, bvalid_q, arrdy_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;
  logic [8:0]    cmd_q;
  logic          ovr_q;
  logic [15:0]   count_q;
  logic [DW-1:0] scr_q [2:NUM_REGS-1];

  logic          busy, done;
  logic          wr_hs, rd_hs, w_in, r_in;
  logic          cmd_wr, start, ovr_set, ovr_clr;
  logic [IW-1:0] w_idx, r_idx;
  logic [8:0]    cmd_d;
  logic [DW-1:0] rdata_d;

  assign s00_axi_awready = awrdy_q;
  assign s00_axi_wready  = awrdy_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arrdy_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign lcd_busy        = busy;

  logic unused_sig;
  assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_comb begin
    wr_hs   = awrdy_q & s00_axi_awvalid & s00_axi_wvalid;
    w_idx   = s00_axi_awaddr[AW-1:2];
    w_in    = int'(w_idx) < NUM_REGS;
    cmd_wr  = wr_hs && (w_idx == IW'(CMD_IDX)) &&
              (|s00_axi_wstrb[1:0]);
    start   = cmd_wr && !busy;
    ovr_set = cmd_wr && busy;
    ovr_clr = wr_hs && (w_idx == IW'(STATUS_IDX)) &&
              s00_axi_wstrb[0] && s00_axi_wdata[1];
    cmd_d   = cmd_q;
    if (s00_axi_wstrb[0]) cmd_d[7:0] = s00_axi_wdata[7:0];
    if (s00_axi_wstrb[1]) cmd_d[8]   = s00_axi_wdata[8];
  end

  // Read mux sees pre-write state, so a same-cycle
  // STATUS write is not visible to the read.
  always_comb begin
    rd_hs   = arrdy_q & s00_axi_arvalid;
    r_idx   = s00_axi_araddr[AW-1:2];
    r_in    = int'(r_idx) < NUM_REGS;
    rdata_d = '0;
    if (r_idx == IW'(CMD_IDX)) begin
      rdata_d[8:0] = cmd_q;
    end else if (r_idx == IW'(STATUS_IDX)) begin
      rdata_d[31:16] = count_q;
      rdata_d[1]     = ovr_q;
      rdata_d[0]     = busy;
    end
    for (int i = 2; i < NUM_REGS; i++)
      if (int'(r_idx) == i) rdata_d = scr_q[i];
  end

  always_ff @(posedge s00_axi_aclk or posedge rst_int) begin
    if (rst_int) begin
      awrdy_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      arrdy_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      cmd_q    <= '0;
      ovr_q    <= 1'b0;
      count_q  <= '0;
      for (int i = 2; i < NUM_REGS; i++) scr_q[i] <= '0;
    end else begin
      awrdy_q <= ~awrdy_q & s00_axi_awvalid &
                 s00_axi_wvalid & ~bvalid_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (!w_in || ovr_set) ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      arrdy_q <= ~arrdy_q & s00_axi_arvalid & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= r_in ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rdata_d;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (start) cmd_q <= cmd_d;
      // A new overrun outranks a concurrent clear.
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
      if (done) count_q <= count_q + 16'd1;

      for (int i = 2; i < NUM_REGS; i++)
        if (wr_hs && int'(w_idx) == i)
          for (int b = 0; b < NB; b++)
            if (s00_axi_wstrb[b])
              scr_q[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
    end
  end

  lcd_bus_seq #(
    .E_PULSE_CYCLES(E_PULSE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES)
  ) u_seq (
    .clk_i     (s00_axi_aclk),
    .rst_i     (rst_int),
    .start_i   (start),
    .data_i    (cmd_d[7:0]),
    .rs_i      (cmd_d[8]),
    .lcd_data_o(lcd_data),
    .lcd_rs_o  (lcd_rs),
    .lcd_e_o   (lcd_e),
    .busy_o    (busy),
    .done_o    (done)
  );

endmodule

// File: tb/tb_lcd_axil_ctrl.sv
// Directed bench for lcd_axil_ctrl (NUM_REGS=6).
// Register access, LCD timing, overrun, reset, backpressure.
module tb_lcd_axil_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic          rvalid, rready;
  logic [7:0]    lcd_data;
  logic          lcd_rs, lcd_e, lcd_busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lcd_axil_ctrl #(.NUM_REGS(6)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (3'b000),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (3'b000),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .lcd_data       (lcd_data),
    .lcd_rs         (lcd_rs),
    .lcd_e          (lcd_e),
    .lcd_busy       (lcd_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge.
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [1:0] resp,
                    output int waits, output int acc);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    waits = 0;
    while (!awready && waits < 50) begin
      @(negedge clk); waits++;
    end
    if (!awready) chk("wr_timeout", 32'd1, 32'd0);
    else chk("wready", {31'd0, wready}, 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk); n++;
    end
    if (!bvalid) chk("b_timeout", 32'd1, 32'd0);
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!arready) chk("ar_timeout", 32'd1, 32'd0);
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk); n++;
    end
    if (!rvalid) chk("r_timeout", 32'd1, 32'd0);
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  // Follow one command to IDLE; acc is the acceptance edge.
  task automatic seq_watch(input int acc, input logic [8:0] c,
                           input string tag);
    int ehi, bad, n;
    ehi = 0; bad = 0; n = 0;
    while (lcd_busy && n < 3000) begin
      if (lcd_e) ehi++;
      if ({lcd_rs, lcd_data} !== c) bad++;
      @(negedge clk); n++;
    end
    chk({tag, "_e_cycles"}, ehi, 32'd50);
    chk({tag, "_busy_len"}, cyc - acc, 32'd2051);
    chk({tag, "_bus_stable"}, bad, 32'd0);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  int          w, acc, hold, stray, n;

  initial begin
    rst = 1; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_lcd", {22'd0, lcd_busy, lcd_e, lcd_rs, lcd_data}, 32'd0);
    rst = 0;
    repeat (3) @(negedge clk);

    rd(5'h04, d, r);
    chk("status_rst", d, 32'h0);

    wr(5'h08, 32'h1, 4'hF, r, w, acc);
    chk("wr_s2_resp", {30'd0, r}, 32'd0);
    wr(5'h0C, 32'h2, 4'hF, r, w, acc);
    rd(5'h08, d, r);
    chk("rd_s2", d, 32'h1);
    chk("rd_s2_resp", {30'd0, r}, 32'd0);
    rd(5'h0C, d, r);
    chk("rd_s3", d, 32'h2);
    wr(5'h10, 32'hAABBCCDD, 4'b0101, r, w, acc);
    rd(5'h10, d, r);
    chk("rd_strb", d, 32'h00BB00DD);

    rd(5'h18, d, r);
    chk("oob_rresp", {30'd0, r}, 32'd2);
    chk("oob_rdata", d, 32'd0);
    wr(5'h18, 32'h5, 4'hF, r, w, acc);
    chk("oob_bresp", {30'd0, r}, 32'd2);

    wr(5'h00, 32'h141, 4'b1100, r, w, acc);
    chk("cmd_nostrb_resp", {30'd0, r}, 32'd0);
    chk("cmd_nostrb_busy", {31'd0, lcd_busy}, 32'd0);
    rd(5'h00, d, r);
    chk("cmd_nostrb_rd", d, 32'h0);

    wr(5'h00, 32'h141, 4'hF, r, w, acc);
    chk("cmd1_resp", {30'd0, r}, 32'd0);
    chk("cmd1_bus", {23'd0, lcd_rs, lcd_data}, 32'h141);
    seq_watch(acc, 9'h141, "cmd1");
    rd(5'h04, d, r);
    chk("status_cnt1", d, 32'h00010000);
    rd(5'h00, d, r);
    chk("cmd_rd", d, 32'h141);

    wr(5'h00, 32'h141, 4'hF, r, w, acc);
    repeat (60) @(negedge clk);
    wr(5'h00, 32'h0AA, 4'hF, r, w, acc);
    chk("ovr_bresp", {30'd0, r}, 32'd2);
    chk("ovr_bus", {23'd0, lcd_rs, lcd_data}, 32'h141);
    rd(5'h04, d, r);
    chk("ovr_status", d, 32'h00010003);
    wr(5'h04, 32'h2, 4'hF, r, w, acc);
    chk("w1c_resp", {30'd0, r}, 32'd0);
    rd(5'h04, d, r);
    chk("w1c_status", d, 32'h00010001);
    n = 0;
    while (lcd_busy && n < 3000) begin
      @(negedge clk); n++;
    end
    rd(5'h04, d, r);
    chk("status_cnt2", d, 32'h00020000);
    rd(5'h00, d, r);
    chk("cmd_kept", d, 32'h141);

    awaddr = 5'h08; wdata = 32'h11; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!awready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'h22;
    hold = 0; stray = 0;
    repeat (10) begin
      if (bvalid) hold++;
      if (awready) stray++;
      @(negedge clk);
    end
    chk("bp_bvalid_held", hold, 32'd10);
    chk("bp_no_accept", stray, 32'd0);
    bready = 1;
    n = 0;
    while (!awready && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    bready = 0;
    rd(5'h08, d, r);
    chk("bp_rd_s2", d, 32'h11);
    rd(5'h0C, d, r);
    chk("bp_rd_s3", d, 32'h22);

    wr(5'h00, 32'h055, 4'hF, r, w, acc);
    chk("pre_rst_e", {31'd0, lcd_e}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("arst_e", {31'd0, lcd_e}, 32'd0);
    chk("arst_busy", {31'd0, lcd_busy}, 32'd0);
    chk("arst_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    wr(5'h08, 32'h77, 4'hF, r, w, acc);
    chk("rel_waits", w, 32'd3);
    chk("rel_resp", {30'd0, r}, 32'd0);
    wr(5'h00, 32'h023, 4'hF, r, w, acc);
    chk("cmd3_bus", {23'd0, lcd_rs, lcd_data}, 32'h023);
    seq_watch(acc, 9'h023, "cmd3");
    rd(5'h04, d, r);
    chk("status_post_rst", d, 32'h00010000);
    rd(5'h0C, d, r);
    chk("scr_cleared", d, 32'h0);
    rd(5'h08, d, r);
    chk("scr_post_rst", d, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
